updown_repeat_counter: RTL
==========================

# updown_repeat_counter

Parametrised up/down counter driven by raw push-button inputs. Each input is debounced and edge-detected, and the count steps once per press. A held button auto-repeats after a programmable delay. Wrap or saturate behaviour, min/max flags and a synchronous load are supported. The block sits between the board button pins and the display/LED logic, and generalises the single-step 8-bit press counter.

## Interface
Parameters:
- WIDTH, 8: count width in bits (2..16).
- MAX_VAL, 2**WIDTH-1: upper count bound; lower bound is 0.
- DEBOUNCE_CYCLES, 4: consecutive identical samples needed to change a debounced level (>=1).
- REPEAT_DELAY, 8: cycles from the first step to the first auto-repeat step; 0 disables auto-repeat.
- REPEAT_PERIOD, 4: cycles between subsequent auto-repeat steps (>=1).
- SATURATE, 0: 0 means wrap at the bounds; 1 means clamp at the bounds.

Ports:
- clk, input, 1: single clock, all state on its rising edge.
- reset, input, 1: synchronous, active-high.
- up, input, 1: raw increment button.
- down, input, 1: raw decrement button.
- load, input, 1: synchronous load strobe.
- load_value, input, WIDTH: value to load; clamped to MAX_VAL.
- count, output, WIDTH: current count.
- at_max, output, 1: registered; high when count == MAX_VAL.
- at_min, output, 1: registered; high when count == 0.
- wrapped, output, 1: one-cycle pulse on a wrap (wrap mode) or on a blocked step at a bound (saturate mode).

## Operation
- Debounce, per input:
  - Keep a stable counter and a registered level (db_up, db_down).
  - A sample that differs from the level increments the counter; a matching sample clears it.
  - When the counter reaches DEBOUNCE_CYCLES, the level flips and the counter clears.
- FSM states: IDLE, HOLD_UP, HOLD_DN, BLOCK. There is one repeat timer of width ceil(log2(max(REPEAT_DELAY, REPEAT_PERIOD)+1)).
- IDLE:
  - Rising db_up alone: step +1, go to HOLD_UP, load the timer for REPEAT_DELAY.
  - Rising db_down alone: same, stepping -1, go to HOLD_DN.
  - Both high (simultaneous rise, or either high without a step): go to BLOCK, no step.
- HOLD_UP and HOLD_DN:
  - Active button released: go to IDLE.
  - Other button becomes high: go to BLOCK, no further steps.
  - Otherwise, when the timer expires (only if REPEAT_DELAY != 0): step again and reload the timer for REPEAT_PERIOD.
- BLOCK: stay until db_up == 0 and db_down == 0, then go to IDLE.
- Step arithmetic (wrap mode):
  - +1 at MAX_VAL gives 0, with wrapped = 1.
  - -1 at 0 gives MAX_VAL, with wrapped = 1.
  - Arithmetic uses WIDTH+1 bits internally, so MAX_VAL < 2**WIDTH-1 wraps correctly.
- Step arithmetic (saturate mode): count holds at the bound and wrapped = 1 for that cycle.
- load priority:
  - load overrides any step in the same cycle.
  - count = min(load_value, MAX_VAL), and wrapped = 0.
  - FSM state and timer are unaffected; repeats continue from the loaded value.
- at_max and at_min are recomputed from the next count value, so they are coincident with count.

## Timing
- Reset values: count = 0, at_min = 1, at_max = 0 (1 only if MAX_VAL == 0, which is illegal), wrapped = 0. FSM is in IDLE, debounce levels are 0, counters and timer are 0.
- Reset mid-hold drops all state. Buttons still held after reset must first debounce high before they can cause a step.
- Press latency: let E0 be the first edge sampling a new raw level.
  - The debounced level flips at edge E(D-1), where D = DEBOUNCE_CYCLES.
  - The first step appears on count after edge E(D).
- Auto-repeat:
  - Second step at E(D)+REPEAT_DELAY.
  - Further steps every REPEAT_PERIOD edges after that.
- Release: steps stop at the edge where the debounced level falls. No step occurs on that edge.
- Glitches shorter than D samples never change the debounced level.
- load: count = min(load_value, MAX_VAL) after the edge sampling load = 1 (one-cycle latency).
- wrapped is high for exactly the cycle following the wrapping edge.

## Test plan
- Defaults, reset, then up high for 5 cycles, then low: count goes 0 to 1 exactly after the 5th edge; no repeat; at_min falls with the step.
- up held 30 cycles: steps at E4, E12, E16, E20, E24, E28, giving count = 6 at the end.
- 3-cycle glitch on up, then an 8-cycle down press: the glitch causes no step. Down from 0 gives count = 255 with wrapped pulsing one cycle and at_max = 1.
- Same down press with SATURATE=1, MAX_VAL=9, starting at 0: count stays 0, wrapped pulses, at_min stays 1.
- up and down rise on the same sample: no step. Release up only: still no step, state is BLOCK. Release down, then press up: count +1.
- Hold up, and on a cycle coinciding with a repeat step assert load with load_value = 300 (WIDTH=9, MAX_VAL=200): count = 200 (load wins). The next repeat goes to 0 with wrapped pulsing. Reset asserted during HOLD_UP gives count = 0 and no step until up re-debounces.

Source files
------------

// File: rtl/updown_repeat_counter.sv
// Debounced up/down push-button counter with auto-repeat, wrap or saturate at
// the bounds, registered min/max flags and a synchronous load.
module updown_repeat_counter #(
    parameter int WIDTH           = 8,
    parameter int MAX_VAL         = 2**WIDTH - 1,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_DELAY    = 8,
    parameter int REPEAT_PERIOD   = 4,
    parameter int SATURATE        = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             up,
    input  logic             down,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] count,
    output logic             at_max,
    output logic             at_min,
    output logic             wrapped,
    output logic [1:0]       dbg_state
);
    localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TMR_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int TMR_W   = (TMR_MAX < 1) ? 1 : $clog2(TMR_MAX + 1);
    localparam logic [WIDTH:0] MAX_EXT = (WIDTH+1)'(MAX_VAL);

    typedef enum logic [1:0] {IDLE = 2'd0, HOLD_UP = 2'd1, HOLD_DN = 2'd2, BLOCK = 2'd3} state_t;

    state_t            state_q, state_d;
    logic [1:0]        db_lvl_q, db_lvl_d, db_prev_q;
    logic [DB_W-1:0]   db_cnt_q [2];
    logic [DB_W-1:0]   db_cnt_d [2];
    logic [TMR_W-1:0]  tmr_q, tmr_d;
    logic [WIDTH-1:0]  count_q, count_d;
    logic              at_max_q, at_max_d, at_min_q, at_min_d, wrapped_q, wrapped_d;
    logic [1:0]        raw;
    logic              db_up, db_dn, rise_up, rise_dn, expire, step_up, step_dn;

    assign raw     = {down, up};
    assign db_up   = db_lvl_q[0];
    assign db_dn   = db_lvl_q[1];
    assign rise_up = db_lvl_q[0] & ~db_prev_q[0];
    assign rise_dn = db_lvl_q[1] & ~db_prev_q[1];
    assign expire  = (REPEAT_DELAY != 0) && (tmr_q == TMR_W'(1));

    // A differing sample advances the counter; D in a row flips the level.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            db_lvl_d[i] = db_lvl_q[i];
            db_cnt_d[i] = '0;
            if (raw[i] != db_lvl_q[i]) begin
                if (db_cnt_q[i] == DB_W'(DEBOUNCE_CYCLES - 1))
                    db_lvl_d[i] = raw[i];
                else
                    db_cnt_d[i] = db_cnt_q[i] + 1'b1;
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state and repeat timer
    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        case (state_q)
            IDLE: begin
                tmr_d = '0;
                if (db_up && db_dn) begin
                    state_d = BLOCK;
                end else if (rise_up) begin
                    state_d = HOLD_UP;
                    tmr_d   = TMR_W'(REPEAT_DELAY);
                end else if (rise_dn) begin
                    state_d = HOLD_DN;
                    tmr_d   = TMR_W'(REPEAT_DELAY);
                end else if (db_up || db_dn) begin
                    state_d = BLOCK;
                end
            end
            HOLD_UP, HOLD_DN: begin
                if ((state_q == HOLD_UP) ? !db_up : !db_dn) begin
                    state_d = IDLE;
                    tmr_d   = '0;
                end else if ((state_q == HOLD_UP) ? db_dn : db_up) begin
                    state_d = BLOCK;
                    tmr_d   = '0;
                end else if (expire) begin
                    tmr_d = TMR_W'(REPEAT_PERIOD);
                end else if (tmr_q != '0) begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            default: begin
                tmr_d = '0;
                if (!db_up && !db_dn) state_d = IDLE;
            end
        endcase
    end

    // Step outputs of the FSM
    always_comb begin
        step_up = 1'b0;
        step_dn = 1'b0;
        case (state_q)
            IDLE: begin
                step_up = rise_up && !db_dn;
                step_dn = rise_dn && !db_up;
            end
            HOLD_UP: step_up = db_up && !db_dn && expire;
            HOLD_DN: step_dn = db_dn && !db_up && expire;
            default: ;
        endcase
    end

    // Count datapath: load beats any step; WIDTH+1 bits so a short MAX_VAL wraps cleanly.
    always_comb begin
        count_d   = count_q;
        wrapped_d = 1'b0;
        if (load) begin
            count_d = ({1'b0, load_value} > MAX_EXT) ? MAX_EXT[WIDTH-1:0] : load_value;
        end else if (step_up) begin
            if ({1'b0, count_q} >= MAX_EXT) begin
                wrapped_d = 1'b1;
                if (SATURATE == 0) count_d = '0;
            end else begin
                count_d = count_q + 1'b1;
            end
        end else if (step_dn) begin
            if (count_q == '0) begin
                wrapped_d = 1'b1;
                if (SATURATE == 0) count_d = MAX_EXT[WIDTH-1:0];
            end else begin
                count_d = count_q - 1'b1;
            end
        end
        at_max_d = ({1'b0, count_d} == MAX_EXT);
        at_min_d = (count_d == '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            db_lvl_q  <= '0;
            db_prev_q <= '0;
            db_cnt_q  <= '{default: '0};
            tmr_q     <= '0;
            count_q   <= '0;
            at_max_q  <= (MAX_VAL == 0);
            at_min_q  <= 1'b1;
            wrapped_q <= 1'b0;
        end else begin
            db_lvl_q  <= db_lvl_d;
            db_prev_q <= db_lvl_q;
            db_cnt_q  <= db_cnt_d;
            tmr_q     <= tmr_d;
            count_q   <= count_d;
            at_max_q  <= at_max_d;
            at_min_q  <= at_min_d;
            wrapped_q <= wrapped_d;
        end
    end

    assign count     = count_q;
    assign at_max    = at_max_q;
    assign at_min    = at_min_q;
    assign wrapped   = wrapped_q;
    assign dbg_state = state_q;
endmodule
